// File: rtl/divide_pkg.sv
// divide_pkg: shared widths, iteration count and FSM encoding for the divider
package divide_pkg;
  localparam int DIV_W = 32;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on a 33-bit partial remainder
module div_step import divide_pkg::*; (
  input  logic [DIV_W:0]   i_rem,
  input  logic             i_bit,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W:0]   o_rem,
  output logic             o_q
);
  logic [DIV_W+1:0] w_shift;
  logic [DIV_W+1:0] w_diff;
  assign w_shift = {i_rem, i_bit};
  assign w_diff = w_shift - {2'b00, i_divisor};
  assign o_q = ~w_diff[DIV_W+1];
  assign o_rem = o_q ? w_diff[DIV_W:0] : w_shift[DIV_W:0];
endmodule

// File: rtl/divide.sv
// divide: 32-step iterative signed/unsigned divider with cancel and one-cycle done pulse
module divide import divide_pkg::*; #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Unsigned,
  input  logic             div_begin,
  input  logic             div_cancel,
  input  logic [DIV_W-1:0] div_op1,
  input  logic [DIV_W-1:0] div_op2,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_end,
  output logic             div_busy
);
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [DIV_W-1:0] r_work;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] r_op1;
  logic [DIV_W:0]   r_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_zero;
  logic [DIV_W:0]   w_next_rem;
  logic             w_qbit;
  logic [DIV_W-1:0] w_q;
  logic [DIV_W-1:0] w_r;

  div_step u_step (
    .i_rem    (r_rem),
    .i_bit    (r_work[DIV_W-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_next_rem),
    .o_q      (w_qbit)
  );

  // r_work shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_q = {r_work[DIV_W-2:0], w_qbit};
  assign w_r = w_next_rem[DIV_W-1:0];
  assign div_busy = r_state != IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_op1     <= '0;
      r_rem     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_zero    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_end   <= 1'b0;
    end else begin
      div_end <= 1'b0;
      if (div_cancel) r_state <= IDLE;
      else
        case (r_state)
          IDLE:
            if (div_begin) begin
              r_state   <= BUSY;
              r_cnt     <= '0;
              r_rem     <= '0;
              r_op1     <= div_op1;
              r_work    <= mag(div_op1, ~Unsigned & div_op1[DIV_W-1]);
              r_divisor <= mag(div_op2, ~Unsigned & div_op2[DIV_W-1]);
              r_zero    <= div_op2 == '0;
              r_qneg    <= ~Unsigned & (div_op1[DIV_W-1] ^ div_op2[DIV_W-1]);
              r_rneg    <= ~Unsigned & div_op1[DIV_W-1];
            end
          BUSY: begin
            r_rem  <= w_next_rem;
            r_work <= w_q;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'(DIV_ITER - 1)) begin
              r_state   <= DONE;
              div_end   <= 1'b1;
              quotient  <= r_zero ? '1 : (r_qneg ? -w_q : w_q);
              remainder <= r_zero ? r_op1 : (r_rneg ? -w_r : w_r);
            end
          end
          default: r_state <= IDLE;
        endcase
    end
endmodule
